// File: rtl/apb_master_pkg.sv
// Shared definitions for the APB master controller: FSM state encoding
// and default parameter values.
package apb_master_pkg;

    localparam int unsigned DEF_ADDR_W    = 8;
    localparam int unsigned DEF_DATA_W    = 8;
    localparam int unsigned DEF_CMD_DEPTH = 4;
    localparam int unsigned DEF_TIMEOUT   = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } apb_state_e;

endpackage

// File: rtl/apb_cmd_fifo.sv
// Command queue for the APB master: power-of-two depth, FIFO order,
// no bypass (a pop on an empty queue is ignored).
module apb_cmd_fifo #(
    parameter int unsigned WIDTH = 17,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full
);

    localparam int unsigned      PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == FULL_CNT);
    assign do_pop  = pop && !empty;
    // A push into a full queue is legal only when the head leaves on the same edge.
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/apb_master_ctrl.sv
// APB master: queues read/write commands and issues them as APB transfers,
// with wait-state timeout and one response pulse per accepted command.
module apb_master_ctrl
    import apb_master_pkg::*;
#(
    parameter int unsigned ADDR_W    = DEF_ADDR_W,
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned CMD_DEPTH = DEF_CMD_DEPTH,
    parameter int unsigned TIMEOUT   = DEF_TIMEOUT
) (
    input  logic              cpu_pclk,
    input  logic              cpu_preset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic              rsp_write,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic [ADDR_W-1:0] cpu_paddr,
    output logic [DATA_W-1:0] cpu_pwdata,
    output logic              cpu_pwrite,
    output logic              cpu_psel,
    output logic              cpu_penable,
    input  logic              cpu_pready,
    input  logic              cpu_pslverr,
    input  logic [DATA_W-1:0] cpu_prdata
);

    localparam int unsigned      CMD_W     = ADDR_W + DATA_W + 1;
    localparam int unsigned      CNT_W     = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    apb_state_e        state_q;
    logic [CNT_W-1:0]  wait_cnt_q;
    logic              ready_en_q;
    logic              psel_q;
    logic              penable_q;
    logic              pwrite_q;
    logic [ADDR_W-1:0] paddr_q;
    logic [DATA_W-1:0] pwdata_q;
    logic              rsp_valid_q;
    logic              rsp_write_q;
    logic [DATA_W-1:0] rsp_rdata_q;
    logic              rsp_err_q;
    logic              rsp_timeout_q;

    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_empty;
    logic              fifo_full;
    logic [CMD_W-1:0]  fifo_rdata;
    logic              head_write;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_wdata;

    // Held low through reset and released one edge after it deasserts.
    assign cmd_ready = ready_en_q && !fifo_full;
    assign fifo_push = cmd_valid && cmd_ready;
    assign fifo_pop  = !fifo_empty &&
                       ((state_q == ST_IDLE) || ((state_q == ST_ACCESS) && cpu_pready));

    assign head_write = fifo_rdata[CMD_W-1];
    assign head_addr  = fifo_rdata[DATA_W +: ADDR_W];
    assign head_wdata = fifo_rdata[DATA_W-1:0];

    apb_cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (CMD_DEPTH)
    ) u_cmd_fifo (
        .clk   (cpu_pclk),
        .rst   (cpu_preset),
        .push  (fifo_push),
        .wdata ({cmd_write, cmd_addr, cmd_wdata}),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    always_ff @(posedge cpu_pclk or posedge cpu_preset) begin
        if (cpu_preset) begin
            state_q       <= ST_IDLE;
            wait_cnt_q    <= '0;
            ready_en_q    <= 1'b0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_write_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            ready_en_q    <= 1'b1;
            rsp_valid_q   <= 1'b0;
            rsp_write_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        state_q   <= ST_SETUP;
                        psel_q    <= 1'b1;
                        penable_q <= 1'b0;
                        pwrite_q  <= head_write;
                        paddr_q   <= head_addr;
                        pwdata_q  <= head_wdata;
                    end
                end
                ST_SETUP: begin
                    state_q    <= ST_ACCESS;
                    penable_q  <= 1'b1;
                    wait_cnt_q <= '0;
                end
                ST_ACCESS: begin
                    if (cpu_pready) begin
                        rsp_valid_q <= 1'b1;
                        rsp_write_q <= pwrite_q;
                        rsp_rdata_q <= pwrite_q ? '0 : cpu_prdata;
                        rsp_err_q   <= cpu_pslverr;
                        penable_q   <= 1'b0;
                        if (!fifo_empty) begin
                            state_q  <= ST_SETUP;
                            pwrite_q <= head_write;
                            paddr_q  <= head_addr;
                            pwdata_q <= head_wdata;
                        end else begin
                            state_q  <= ST_IDLE;
                            psel_q   <= 1'b0;
                            pwrite_q <= 1'b0;
                            paddr_q  <= '0;
                            pwdata_q <= '0;
                        end
                    end else if (wait_cnt_q == WAIT_LAST) begin
                        // Timeout always passes through IDLE before the next command.
                        rsp_valid_q   <= 1'b1;
                        rsp_write_q   <= pwrite_q;
                        rsp_err_q     <= 1'b1;
                        rsp_timeout_q <= 1'b1;
                        state_q       <= ST_IDLE;
                        psel_q        <= 1'b0;
                        penable_q     <= 1'b0;
                        pwrite_q      <= 1'b0;
                        paddr_q       <= '0;
                        pwdata_q      <= '0;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    psel_q    <= 1'b0;
                    penable_q <= 1'b0;
                end
            endcase
        end
    end

    assign cpu_psel    = psel_q;
    assign cpu_penable = penable_q;
    assign cpu_pwrite  = pwrite_q;
    assign cpu_paddr   = paddr_q;
    assign cpu_pwdata  = pwdata_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_write   = rsp_write_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_timeout_q;

endmodule
